// File: rtl/sprite_loader.sv
// Streams packed 4-bit palette indices into the sprite RAM and serves the display read port.
// Define SPRITE_LOADER_CHECKSUM_EN to add a 16-bit running sum of accepted bytes.
module sprite_loader #(
   parameter int PIXELS    = 21293,
   parameter int ADDR_W    = 15,
   parameter int MAX_INDEX = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        busy,
   output logic        done,
   output logic        bad_index,
   input  logic [19:0] rd_address,
   output logic [3:0]  rd_data
`ifdef SPRITE_LOADER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] PIXELS_C  = CNT_W'(PIXELS);
   localparam logic [3:0]       MAX_NIB_C = 4'(MAX_INDEX);

   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next, count_inc;
   logic [3:0]       lo_nib_reg, lo_nib_next;
   logic             bad_reg, bad_next;
   logic             wr_en;
   logic [3:0]       wr_nib;
   logic [ADDR_W-1:0] wr_addr;
   logic             accept;

   logic [3:0] mem [0:DEPTH-1];

   // Only the low ADDR_W address bits select a RAM word; the rest alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^rd_address[19:ADDR_W];

   assign count_inc = count_reg + 1'b1;
   assign wr_addr   = count_reg[ADDR_W-1:0];
   assign bad_index = bad_reg;

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      lo_nib_next = lo_nib_reg;
      bad_next    = bad_reg;
      wr_en       = 1'b0;
      wr_nib      = lo_nib_reg;
      in_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = HI;
               count_next = '0;
               bad_next   = 1'b0;
            end
         end
         HI: begin
            busy     = 1'b1;
            in_ready = !start;
            if (start) begin
               count_next = '0;
               bad_next   = 1'b0;
            end else if (in_valid) begin
               accept      = 1'b1;
               wr_en       = 1'b1;
               wr_nib      = in_data[7:4];
               lo_nib_next = in_data[3:0];
               count_next  = count_inc;
               state_next  = (count_inc == PIXELS_C) ? DONE : LO;
            end
         end
         LO: begin
            busy = 1'b1;
            if (start) begin
               // Restart drops the latched low nibble without writing it.
               state_next = HI;
               count_next = '0;
               bad_next   = 1'b0;
            end else begin
               wr_en      = 1'b1;
               wr_nib     = lo_nib_reg;
               count_next = count_inc;
               state_next = (count_inc == PIXELS_C) ? DONE : HI;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = HI;
               count_next = '0;
               bad_next   = 1'b0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Out-of-range indices are flagged but still stored as received.
      if (wr_en && (wr_nib > MAX_NIB_C)) begin
         bad_next = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         lo_nib_reg <= '0;
         bad_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         lo_nib_reg <= lo_nib_next;
         bad_reg    <= bad_next;
      end
   end

   // RAM contents deliberately survive reset so a partial image stays visible.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_nib;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_address[ADDR_W-1:0]];
      end
   end

`ifdef SPRITE_LOADER_CHECKSUM_EN
   logic [15:0] checksum_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         checksum_reg <= '0;
      end else if (start) begin
         checksum_reg <= '0;
      end else if (accept) begin
         checksum_reg <= checksum_reg + {8'h00, in_data};
      end
   end

   assign checksum = checksum_reg;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: two small instances (6 and 5 pixels, 8-word RAM) against a pixel-list model.
module tb_sprite_loader;

   logic clk = 1'b0;
   logic rst;
   logic        start_s [2];
   logic [7:0]  data_s  [2];
   logic        valid_s [2];
   logic        ready_s [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic        bad_s   [2];
   logic [19:0] addr_s  [2];
   logic [3:0]  rdata_s [2];
`ifdef SPRITE_LOADER_CHECKSUM_EN
   logic [15:0] cks_s   [2];
`endif

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      sprite_loader #(
         .PIXELS    ((gi == 0) ? 6 : 5),
         .ADDR_W    (3),
         .MAX_INDEX (4)
      ) u_dut (
         .Clk        (clk),
         .Reset      (rst),
         .start      (start_s[gi]),
         .in_data    (data_s[gi]),
         .in_valid   (valid_s[gi]),
         .in_ready   (ready_s[gi]),
         .busy       (busy_s[gi]),
         .done       (done_s[gi]),
         .bad_index  (bad_s[gi]),
         .rd_address (addr_s[gi]),
         .rd_data    (rdata_s[gi])
`ifdef SPRITE_LOADER_CHECKSUM_EN
         ,
         .checksum   (cks_s[gi])
`endif
      );
   end

   // Model: the RAM as a plain array, filled one pixel at a time in stream order.
   logic [3:0]  model_mem   [2][8];
   bit          model_known [2][8];
   bit          model_bad   [2];
   logic [15:0] model_cks   [2];
   int          pix [2] = '{6, 5};
   bit          ready_log [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic model_write(input int k, input int p, input logic [3:0] nib);
      model_mem[k][p % 8]   = nib;
      model_known[k][p % 8] = 1'b1;
      if (nib > 4'd4) model_bad[k] = 1'b1;
   endtask

   task automatic read_ram(input int k, input int addr, output logic [3:0] v);
      @(negedge clk);
      addr_s[k] = 20'(addr);
      @(negedge clk);
      v = rdata_s[k];
   endtask

   // Drives one load; optionally restarts once, restart_delay cycles after the restart_at-th byte.
   task automatic run_load(input int k, input logic [7:0] bytes [$], input int restart_at,
                           input int restart_delay, input bit rand_valid,
                           output int acc, output int dones, output int done_cyc,
                           output logic ready_at_start, output logic [15:0] cks_done,
                           output bit timeout);
      int p, idx, since, tail;
      bit pend, restarted, seen, do_restart;
      logic [3:0] pend_nib;
      logic [7:0] b;
      acc = 0; dones = 0; done_cyc = -1; ready_at_start = 1'b0; cks_done = '0; timeout = 1'b1;
      p = 0; idx = 0; since = 0; tail = 0; pend = 0; restarted = 0; seen = 0; pend_nib = '0;
      ready_log.delete();
      @(negedge clk);
      start_s[k] = 1'b1; valid_s[k] = 1'b0;
      model_bad[k] = 1'b0; model_cks[k] = '0;
      @(negedge clk);
      for (int cyc = 0; cyc < 400; cyc++) begin
         since++;
         do_restart = (restart_at >= 0) && !restarted && (acc == restart_at) && (since == restart_delay);
         if (do_restart) begin
            pend = 0; p = 0; model_bad[k] = 1'b0; model_cks[k] = '0; restarted = 1;
         end else if (pend) begin
            model_write(k, p, pend_nib); p++; pend = 0;
         end
         start_s[k] = do_restart;
         valid_s[k] = (idx < bytes.size()) && (!rand_valid || ($urandom_range(0, 3) != 0));
         data_s[k]  = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
         #1;
         if (do_restart) ready_at_start = ready_s[k];
         if (busy_s[k]) ready_log.push_back(ready_s[k]);
         if (done_s[k]) begin
            dones++;
            if (!seen) begin
               done_cyc = cyc;
`ifdef SPRITE_LOADER_CHECKSUM_EN
               cks_done = cks_s[k];
`endif
            end
            seen = 1;
         end
         if (valid_s[k] && ready_s[k]) begin
            b = bytes[idx]; idx++; acc++; since = 0;
            model_write(k, p, b[7:4]); p++;
            if (p < pix[k]) begin pend = 1; pend_nib = b[3:0]; end
            model_cks[k] = model_cks[k] + {8'h00, b};
         end
         if (seen) begin
            tail++;
            if (tail == 3) begin timeout = 1'b0; break; end
         end
         @(negedge clk);
      end
      start_s[k] = 1'b0; valid_s[k] = 1'b0;
   endtask

   int acc, dones, done_cyc;
   logic ready_at_start;
   logic [15:0] cks_done;
   bit timeout;
   logic [3:0] rv;
   logic [7:0] q [$];

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 0; valid_s[k] = 0; data_s[k] = '0; addr_s[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_checks++; if ({ready_s[k], busy_s[k], done_s[k], bad_s[k]} !== 4'b0000)
            $display("FAIL reset_flags[%0d]: got rdy/busy/done/bad=%b want 0000", k,
                     {ready_s[k], busy_s[k], done_s[k], bad_s[k]}); else n_pass++;
         n_checks++; if (rdata_s[k] !== 4'h0)
            $display("FAIL reset_rd_data[%0d]: got %h want 0", k, rdata_s[k]); else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_even_load();
      logic [3:0] exp [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      logic [31:0] pat;
      q = '{8'h01, 8'h23, 8'h40};
      run_load(0, q, -1, 0, 1'b0, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      pat = '0;
      foreach (ready_log[i]) pat = {pat[30:0], ready_log[i]};
      n_checks++; if (timeout !== 1'b0) $display("FAIL even_timeout: got %0d want 0", timeout); else n_pass++;
      n_checks++; if (ready_log.size() != 6 || pat !== 32'b101010)
         $display("FAIL even_ready_pattern: got %0d entries %b want 6 entries 101010", ready_log.size(), pat); else n_pass++;
      n_checks++; if (dones != 1 || done_cyc != 6)
         $display("FAIL even_done: got %0d pulses at cycle %0d want 1 at 6", dones, done_cyc); else n_pass++;
      n_checks++; if (bad_s[0] !== 1'b0) $display("FAIL even_bad_index: got %b want 0", bad_s[0]); else n_pass++;
      for (int a = 0; a < 6; a++) begin
         read_ram(0, a, rv);
         n_checks++; if (rv !== exp[a]) $display("FAIL even_ram[%0d]: got %h want %h", a, rv, exp[a]); else n_pass++;
      end
   endtask

   task automatic test_odd_load();
      logic [3:0] exp [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};
      q = '{8'h12, 8'h34, 8'h4F};
      run_load(1, q, -1, 0, 1'b0, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (timeout !== 1'b0 || acc != 3) $display("FAIL odd_accept: got %0d bytes timeout=%0d want 3 bytes", acc, timeout); else n_pass++;
      n_checks++; if (dones != 1 || done_cyc != 5)
         $display("FAIL odd_done: got %0d pulses at cycle %0d want 1 at 5", dones, done_cyc); else n_pass++;
      n_checks++; if (bad_s[1] !== 1'b0) $display("FAIL odd_bad_index: got %b want 0", bad_s[1]); else n_pass++;
      for (int a = 0; a < 5; a++) begin
         read_ram(1, a, rv);
         n_checks++; if (rv !== exp[a]) $display("FAIL odd_ram[%0d]: got %h want %h", a, rv, exp[a]); else n_pass++;
      end
   endtask

   task automatic test_bad_index();
      q = '{8'h51, 8'h00, 8'h00};
      run_load(1, q, -1, 0, 1'b1, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (bad_s[1] !== 1'b1) $display("FAIL bad_set: got %b want 1", bad_s[1]); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++; if (bad_s[1] !== 1'b1) $display("FAIL bad_sticky: got %b want 1", bad_s[1]); else n_pass++;
      q = '{8'h01, 8'h23, 8'h40};
      run_load(1, q, -1, 0, 1'b0, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (bad_s[1] !== 1'b0) $display("FAIL bad_cleared: got %b want 0", bad_s[1]); else n_pass++;
   endtask

   task automatic test_restart(input int delay);
      q = '{8'h12, 8'h30, 8'h44, 8'h44, 8'h44};
      run_load(0, q, 2, delay, 1'b0, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (timeout !== 1'b0 || acc != 5 || dones != 1)
         $display("FAIL restart%0d_flow: got acc=%0d dones=%0d timeout=%0d want 5 1 0", delay, acc, dones, timeout); else n_pass++;
      n_checks++; if (ready_at_start !== 1'b0)
         $display("FAIL restart%0d_ready_in_start: got %b want 0", delay, ready_at_start); else n_pass++;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      n_checks++; if (cks_done !== 16'h00CC) $display("FAIL restart%0d_checksum: got %h want 00cc", delay, cks_done); else n_pass++;
`endif
      for (int a = 0; a < 6; a++) begin
         read_ram(0, a, rv);
         n_checks++; if (rv !== 4'd4) $display("FAIL restart%0d_ram[%0d]: got %h want 4", delay, a, rv); else n_pass++;
      end
   endtask

   task automatic test_reset_midload();
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = 8'h37;
      @(negedge clk);
      valid_s[0] = 1'b0;
      model_write(0, 0, 4'h3);
      n_checks++; if (busy_s[0] !== 1'b1) $display("FAIL midload_busy_before: got %b want 1", busy_s[0]); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_checks++; if ({ready_s[0], busy_s[0], done_s[0], bad_s[0]} !== 4'b0000)
         $display("FAIL midload_reset_flags: got %b want 0000", {ready_s[0], busy_s[0], done_s[0], bad_s[0]}); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      read_ram(0, 0, rv);
      n_checks++; if (rv !== 4'h3) $display("FAIL midload_partial_kept: got %h want 3", rv); else n_pass++;
      q = '{8'h21, 8'h43, 8'h02};
      run_load(0, q, -1, 0, 1'b0, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (timeout !== 1'b0 || dones != 1 || done_cyc != 6)
         $display("FAIL midload_reload: got dones=%0d cycle=%0d timeout=%0d want 1 6 0", dones, done_cyc, timeout); else n_pass++;
      for (int a = 0; a < 6; a++) begin
         read_ram(0, a, rv);
         n_checks++; if (rv !== model_mem[0][a]) $display("FAIL midload_ram[%0d]: got %h want %h", a, rv, model_mem[0][a]); else n_pass++;
      end
   endtask

   task automatic test_readback();
      q = '{8'h30, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      run_load(0, q, -1, 0, 1'b1, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      read_ram(0, 0, rv);
      n_checks++; if (rv !== 4'h3) $display("FAIL readback_addr0: got %h want 3", rv); else n_pass++;
      read_ram(0, 1, rv);
      n_checks++; if (rv !== 4'h0) $display("FAIL readback_addr1: got %h want 0", rv); else n_pass++;
      read_ram(0, pix[0] + 3, rv);
      n_checks++; if (rv !== 4'h0) $display("FAIL readback_above_pixels: got %h want 0", rv); else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int k;
         k = it % 2;
         q.delete();
         for (int i = 0; i < (pix[k] + 1) / 2; i++) begin
            logic [3:0] h, l;
            h = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            q.push_back({h, l});
         end
         run_load(k, q, -1, 0, 1'b1, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
         n_checks++; if (timeout !== 1'b0 || dones != 1)
            $display("FAIL random%0d_done: got dones=%0d timeout=%0d want 1 0", it, dones, timeout); else n_pass++;
         n_checks++; if (bad_s[k] !== model_bad[k])
            $display("FAIL random%0d_bad_index: got %b want %b", it, bad_s[k], model_bad[k]); else n_pass++;
`ifdef SPRITE_LOADER_CHECKSUM_EN
         n_checks++; if (cks_done !== model_cks[k])
            $display("FAIL random%0d_checksum: got %h want %h", it, cks_done, model_cks[k]); else n_pass++;
`endif
         for (int a = 0; a < pix[k]; a++) begin
            read_ram(k, a, rv);
            n_checks++; if (rv !== model_mem[k][a])
               $display("FAIL random%0d_ram[%0d]: got %h want %h", it, a, rv, model_mem[k][a]); else n_pass++;
         end
      end
   endtask

`ifdef SPRITE_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      q = '{8'hFF, 8'hFF, 8'h02};
      run_load(0, q, -1, 0, 1'b1, acc, dones, done_cyc, ready_at_start, cks_done, timeout);
      n_checks++; if (cks_done !== 16'h0200) $display("FAIL checksum_at_done: got %h want 0200", cks_done); else n_pass++;
      repeat (4) @(negedge clk);
      n_checks++; if (cks_s[0] !== 16'h0200) $display("FAIL checksum_hold: got %h want 0200", cks_s[0]); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_even_load();
      test_odd_load();
      test_bad_index();
      test_restart(1);
      test_restart(2);
      test_reset_midload();
      test_readback();
      test_random();
`ifdef SPRITE_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Write side of the intro sprite memories. Accepts a byte stream of packed 4-bit palette indices over a valid/ready handshake and fills an on-chip sprite RAM.
- The display path (intro address generator → color mapper) reads the same RAM through a registered read port.
- This replaces a fixed $readmemh image, so intro panels and subtitles can be reloaded at run time.

Parameters:
- PIXELS, 21293, number of 4-bit pixels in one sprite (199 x 107 panel).
- ADDR_W, 15, RAM address width; 2^ADDR_W must be at least PIXELS.
- MAX_INDEX, 4, highest legal palette index (the palette has 5 entries, 0..4).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin or restart a load at pixel 0.
- in_data  in  8  packed pixels; high nibble is the earlier pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- busy  out  1  a load is in progress; the color mapper must not display this sprite.
- done  out  1  one-cycle pulse when the last pixel is written.
- bad_index  out  1  sticky flag; a nibble greater than MAX_INDEX was received during the current load.
- rd_address  in  20  display read address (intro_address).
- rd_data  out  4  palette index at rd_address, registered.

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, bad_index=0, rd_data=0, pixel counter=0, FSM=IDLE. RAM contents are not cleared.
- FSM states are IDLE, HI, LO, DONE.
- IDLE: in_ready=0, busy=0. On start, go to HI, clear the counter and bad_index, set busy=1.
- HI:
  - in_ready=1.
  - On in_valid&&in_ready, write the high nibble to RAM[count], latch the low nibble, increment count.
  - If the incremented count equals PIXELS, go to DONE. Otherwise go to LO.
- LO:
  - in_ready=0.
  - Write the latched low nibble to RAM[count] and increment count.
  - If count now equals PIXELS, go to DONE. Otherwise go to HI.
- Write rate and odd PIXELS:
  - The RAM has a single write port, so at most one byte is accepted every 2 cycles.
  - If PIXELS is odd, the low nibble of the final byte is discarded.
- DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then go to IDLE.
- start while in HI or LO: the load restarts. Counter goes to 0, the latched nibble is dropped, bad_index is cleared, state goes to HI. A byte presented in that same cycle is not accepted (in_ready is forced to 0 in the start cycle).
- start in DONE: takes priority over the return to IDLE. done still pulses and the next state is HI.
- Counter width is ADDR_W+1; it never exceeds PIXELS and does not wrap.
- Nibble range check: any written nibble greater than MAX_INDEX sets bad_index. The nibble is still written unchanged; the palette lookup is the downstream block's concern.
- Read port:
  - rd_data <= RAM[rd_address[ADDR_W-1:0]] on every Clk edge, 1-cycle latency, independent of FSM state.
  - rd_address at or above PIXELS returns RAM contents unchanged.
  - Read and write to the same address in the same cycle returns the old data.
- Reset mid-load: state returns immediately to IDLE and outputs take their reset values. RAM keeps the partial image.
- in_valid held with in_ready=0 never writes. in_data must be held stable by the sender until it is accepted.

Optional Feature:
- Macro SPRITE_LOADER_CHECKSUM_EN.
- Defined: extra output checksum[15:0], the mod-2^16 sum of every accepted in_data byte. Cleared on Reset and on start; valid when done pulses; holds until the next start.
- Undefined: no checksum port and no adder.

Test Plan:
- Load with PIXELS=6 (test override), bytes 0x01, 0x23, 0x40, in_valid always high → RAM[0..5] = 0,1,2,3,4,0. in_ready pattern 1,0,1,0,1,0. done pulses one cycle after the last LO write. bad_index=0.
- PIXELS=5, bytes 0x12, 0x34, 0x4F → RAM[4]=4, nibble F discarded, done pulses, bad_index=0. Byte 0x51 at index 0 in a separate load → bad_index=1 and stays high until the next start.
- start asserted after 2 bytes accepted, then 3 new bytes 0x44 → RAM[0..5] all 4. Exactly one done pulse, after the new stream completes.
- Reset asserted while in LO → in_ready, busy, done drop asynchronously. A later start loads normally from pixel 0.
- Write 0x30 via stream, then drive rd_address=0 and 1 → rd_data=3, then 0, each one cycle after the address. rd_address=PIXELS+3 → rd_data reflects RAM contents, no X.
- With SPRITE_LOADER_CHECKSUM_EN: bytes 0xFF, 0xFF, 0x02 → checksum=0x0200 at done.
